// File: rtl/flash_pkg.sv
// Shared types and constants for the flash read controller.
package flash_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StAck
  } flash_state_e;

  // Port indices as seen by the arbiter and the grant register
  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  localparam int unsigned DefWaitCycles = 4;

endpackage

// File: rtl/flash_rr_arb.sv
// Two-way round-robin arbiter. Purely combinational; the last-grant state
// lives in the parent so it only advances when a grant is actually taken.
module flash_rr_arb
  import flash_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_gnt_i,
  input  logic       en_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o
);

  // Pick the lone requester, or the port that did not win the last tie
  always_comb begin
    gnt_o     = 2'b00;
    gnt_idx_o = P0;
    if (req_i == 2'b11) begin
      gnt_idx_o = ~last_gnt_i;
    end else if (req_i[1]) begin
      gnt_idx_o = P1;
    end
    if (en_i && (req_i != 2'b00)) begin
      gnt_o = 2'b01 << gnt_idx_o;
    end
  end

endmodule

// File: rtl/flash_arb_ctrl.sv
// Read-only NOR flash controller sharing the flash pads between two
// Wishbone slave ports (CPU fetch and boot shadow copier).
module flash_arb_ctrl
  import flash_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DefWaitCycles,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [21:0] s0_adr_i,
  input  logic        s0_stb_i,
  input  logic        s0_cyc_i,
  output logic [15:0] s0_dat_o,
  output logic        s0_ack_o,
  input  logic [21:0] s1_adr_i,
  input  logic        s1_stb_i,
  input  logic        s1_cyc_i,
  output logic [15:0] s1_dat_o,
  output logic        s1_ack_o,
  output logic [21:0] flash_addr_,
  input  logic [15:0] flash_data_,
  output logic        flash_we_n_,
  output logic        flash_oe_n_,
  output logic        flash_ce_n_,
  output logic        flash_rst_n_
);

  flash_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_gnt_q;
  logic             cur_q;
  logic             s0_ack_q, s1_ack_q;
  logic             oe_n_q, ce_n_q;
  logic [21:0]      addr_q;
  logic [15:0]      data_q;

  logic [1:0]       req;
  logic [1:0]       gnt;
  logic             gnt_idx;
  logic             cur_cyc;

  assign req     = {s1_stb_i & s1_cyc_i, s0_stb_i & s0_cyc_i};
  assign cur_cyc = (cur_q == P1) ? s1_cyc_i : s0_cyc_i;

  flash_rr_arb u_arb (
    .req_i      (req),
    .last_gnt_i (last_gnt_q),
    .en_i       (state_q == StIdle),
    .gnt_o      (gnt),
    .gnt_idx_o  (gnt_idx)
  );

  // Access sequencer: grant, hold pads for WAIT_CYCLES+1 clocks, capture, ack
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      last_gnt_q <= P1;
      cur_q      <= P0;
      s0_ack_q   <= 1'b0;
      s1_ack_q   <= 1'b0;
      oe_n_q     <= 1'b1;
      ce_n_q     <= 1'b1;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          s0_ack_q <= 1'b0;
          s1_ack_q <= 1'b0;
          if (gnt != 2'b00) begin
            // Only contention advances the round-robin pointer
            if (req == 2'b11) begin
              last_gnt_q <= gnt_idx;
            end
            cur_q   <= gnt_idx;
            addr_q  <= (gnt_idx == P1) ? s1_adr_i : s0_adr_i;
            oe_n_q  <= 1'b0;
            ce_n_q  <= 1'b0;
            cnt_q   <= CNT_W'(WAIT_CYCLES);
            state_q <= StAccess;
          end
        end
        StAccess: begin
          if (!cur_cyc) begin
            oe_n_q  <= 1'b1;
            ce_n_q  <= 1'b1;
            state_q <= StIdle;
          end else if (cnt_q == '0) begin
            data_q  <= flash_data_;
            oe_n_q  <= 1'b1;
            ce_n_q  <= 1'b1;
            if (cur_q == P1) begin
              s1_ack_q <= 1'b1;
            end else begin
              s0_ack_q <= 1'b1;
            end
            state_q <= StAck;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StAck: begin
          // One-cycle gap so the master's lingering stb is not re-sampled
          s0_ack_q <= 1'b0;
          s1_ack_q <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign s0_dat_o     = data_q;
  assign s1_dat_o     = data_q;
  assign s0_ack_o     = s0_ack_q;
  assign s1_ack_o     = s1_ack_q;
  assign flash_addr_  = addr_q;
  assign flash_oe_n_  = oe_n_q;
  assign flash_ce_n_  = ce_n_q;
  assign flash_we_n_  = 1'b1;
  assign flash_rst_n_ = 1'b1;

endmodule

// File: tb/tb_flash_arb_ctrl.sv
// Directed bench for flash_arb_ctrl: a WAIT_CYCLES=4 instance and a
// WAIT_CYCLES=0 instance driven from the same master stimulus.
module tb_flash_arb_ctrl;

  logic        clk;
  logic        rst;
  logic [21:0] s0_adr, s1_adr;
  logic        s0_stb, s0_cyc, s1_stb, s1_cyc;

  logic [15:0] s0_dat, s1_dat, f_data;
  logic        s0_ack, s1_ack;
  logic [21:0] f_addr;
  logic        f_we_n, f_oe_n, f_ce_n, f_rst_n;

  logic [15:0] z_s0_dat, z_s1_dat, z_data;
  logic        z_s0_ack, z_s1_ack;
  logic [21:0] z_addr;
  logic        z_we_n, z_oe_n, z_ce_n, z_rst_n;

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  int ack1_cnt = 0;

  function automatic logic [15:0] flash_model(input logic [21:0] a);
    case (a)
      22'h000123: return 16'hBEEF;
      22'h3FFFFF: return 16'h0001;
      default:    return a[15:0] ^ 16'hA5A5;
    endcase
  endfunction

  assign f_data = flash_model(f_addr);
  assign z_data = flash_model(z_addr);

  flash_arb_ctrl #(.WAIT_CYCLES(4), .CNT_W(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .s0_adr_i(s0_adr), .s0_stb_i(s0_stb), .s0_cyc_i(s0_cyc),
    .s0_dat_o(s0_dat), .s0_ack_o(s0_ack),
    .s1_adr_i(s1_adr), .s1_stb_i(s1_stb), .s1_cyc_i(s1_cyc),
    .s1_dat_o(s1_dat), .s1_ack_o(s1_ack),
    .flash_addr_(f_addr), .flash_data_(f_data), .flash_we_n_(f_we_n),
    .flash_oe_n_(f_oe_n), .flash_ce_n_(f_ce_n), .flash_rst_n_(f_rst_n)
  );

  flash_arb_ctrl #(.WAIT_CYCLES(0), .CNT_W(4)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .s0_adr_i(s0_adr), .s0_stb_i(s0_stb), .s0_cyc_i(s0_cyc),
    .s0_dat_o(z_s0_dat), .s0_ack_o(z_s0_ack),
    .s1_adr_i(s1_adr), .s1_stb_i(s1_stb), .s1_cyc_i(s1_cyc),
    .s1_dat_o(z_s1_dat), .s1_ack_o(z_s1_ack),
    .flash_addr_(z_addr), .flash_data_(z_data), .flash_we_n_(z_we_n),
    .flash_oe_n_(z_oe_n), .flash_ce_n_(z_ce_n), .flash_rst_n_(z_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watch the WAIT_CYCLES=4 instance for overlapping acks and count s1 acks
  always @(negedge clk) begin
    if (s0_ack && s1_ack) overlap++;
    if (s1_ack) ack1_cnt++;
  end

  task automatic idle_inputs;
    s0_stb = 1'b0; s0_cyc = 1'b0; s1_stb = 1'b0; s1_cyc = 1'b0;
    s0_adr = '0;   s1_adr = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (s0_ack !== 1'b0 || s1_ack !== 1'b0) begin
      errors++; $display("FAIL reset_acks got %b%b want 00", s0_ack, s1_ack);
    end
    checks++; if (f_ce_n !== 1'b1 || f_oe_n !== 1'b1) begin
      errors++; $display("FAIL reset_pads ce_n=%b oe_n=%b want 1 1", f_ce_n, f_oe_n);
    end
    checks++; if (f_addr !== 22'h0 || s0_dat !== 16'h0) begin
      errors++; $display("FAIL reset_addr_data got %h/%h want 0/0", f_addr, s0_dat);
    end
    checks++; if (f_we_n !== 1'b1 || f_rst_n !== 1'b1) begin
      errors++; $display("FAIL tied_pins we_n=%b rst_n=%b want 1 1", f_we_n, f_rst_n);
    end
  endtask

  task automatic test_single_read;
    do_reset();
    s0_adr = 22'h000123; s0_stb = 1'b1; s0_cyc = 1'b1;
    @(posedge clk); #1;  // edge N: grant
    checks++; if (f_ce_n !== 1'b0 || f_oe_n !== 1'b0 || f_addr !== 22'h000123) begin
      errors++; $display("FAIL single_grant ce_n=%b oe_n=%b addr=%h want 0 0 000123",
                         f_ce_n, f_oe_n, f_addr);
    end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      checks++; if (f_ce_n !== 1'b0 || f_oe_n !== 1'b0 || s0_ack !== 1'b0) begin
        errors++; $display("FAIL single_wait%0d ce_n=%b oe_n=%b ack=%b want 0 0 0",
                           k, f_ce_n, f_oe_n, s0_ack);
      end
    end
    @(posedge clk); #1;  // edge N+5: capture
    checks++; if (s0_ack !== 1'b1 || s0_dat !== 16'hBEEF) begin
      errors++; $display("FAIL single_ack ack=%b dat=%h want 1 BEEF", s0_ack, s0_dat);
    end
    checks++; if (f_ce_n !== 1'b1 || f_oe_n !== 1'b1 || s1_ack !== 1'b0) begin
      errors++; $display("FAIL single_release ce_n=%b oe_n=%b s1_ack=%b want 1 1 0",
                         f_ce_n, f_oe_n, s1_ack);
    end
    s0_stb = 1'b0; s0_cyc = 1'b0;
    @(posedge clk); #1;
    checks++; if (s0_ack !== 1'b0 || f_addr !== 22'h000123) begin
      errors++; $display("FAIL single_ack_drop ack=%b addr=%h want 0 000123", s0_ack, f_addr);
    end
  endtask

  task automatic test_simultaneous;
    int ov0;
    do_reset();
    ov0 = overlap;
    s0_adr = 22'h10; s1_adr = 22'h20;
    s0_stb = 1'b1; s0_cyc = 1'b1; s1_stb = 1'b1; s1_cyc = 1'b1;
    @(posedge clk); #1;
    checks++; if (f_addr !== 22'h10 || f_ce_n !== 1'b0) begin
      errors++; $display("FAIL sim_first addr=%h ce_n=%b want 10 0", f_addr, f_ce_n);
    end
    repeat (5) @(posedge clk); #1;
    checks++; if (s0_ack !== 1'b1 || s1_ack !== 1'b0) begin
      errors++; $display("FAIL sim_ack0 acks=%b%b want s0=1 s1=0", s0_ack, s1_ack);
    end
    s0_stb = 1'b0; s0_cyc = 1'b0;
    @(posedge clk); #1;  // ACK gap
    checks++; if (f_ce_n !== 1'b1 || f_addr !== 22'h10) begin
      errors++; $display("FAIL sim_gap ce_n=%b addr=%h want 1 10", f_ce_n, f_addr);
    end
    @(posedge clk); #1;
    checks++; if (f_addr !== 22'h20 || f_ce_n !== 1'b0) begin
      errors++; $display("FAIL sim_second addr=%h ce_n=%b want 20 0", f_addr, f_ce_n);
    end
    repeat (5) @(posedge clk); #1;
    checks++; if (s1_ack !== 1'b1 || s0_ack !== 1'b0 || s1_dat !== 16'hA585) begin
      errors++; $display("FAIL sim_ack1 acks=%b%b dat=%h want s1=1 s0=0 A585",
                         s1_ack, s0_ack, s1_dat);
    end
    s1_stb = 1'b0; s1_cyc = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (overlap !== ov0) begin
      errors++; $display("FAIL sim_overlap count=%0d want %0d", overlap, ov0);
    end
  endtask

  task automatic test_fairness;
    int seq[8];
    int n;
    int c0;
    int c1;
    int ov0;
    do_reset();
    ov0 = overlap;
    n = 0; c0 = 0; c1 = 0;
    s0_adr = 22'h40; s1_adr = 22'h80;
    s0_stb = 1'b1; s0_cyc = 1'b1; s1_stb = 1'b1; s1_cyc = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (n >= 8) break;
      @(posedge clk); #1;
      if (s0_ack) begin seq[n] = 0; n++; c0++; end
      else if (s1_ack) begin seq[n] = 1; n++; c1++; end
    end
    idle_inputs();
    checks++; if (n !== 8) begin
      errors++; $display("FAIL fair_timeout acks=%0d want 8", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++; if (seq[i] !== (i % 2)) begin
        errors++; $display("FAIL fair_order[%0d] got %0d want %0d", i, seq[i], i % 2);
      end
    end
    checks++; if (c0 !== 4 || c1 !== 4) begin
      errors++; $display("FAIL fair_counts s0=%0d s1=%0d want 4 4", c0, c1);
    end
    repeat (3) @(posedge clk); #1;
    checks++; if (overlap !== ov0 || f_ce_n !== 1'b1) begin
      errors++; $display("FAIL fair_end overlap=%0d ce_n=%b want %0d 1", overlap, f_ce_n, ov0);
    end
  endtask

  task automatic test_abort;
    int a1;
    do_reset();
    a1 = ack1_cnt;
    s1_adr = 22'h55; s1_stb = 1'b1; s1_cyc = 1'b1;
    @(posedge clk); #1;  // s1 granted alone
    s0_adr = 22'h77; s0_stb = 1'b1; s0_cyc = 1'b1;
    repeat (2) @(posedge clk); #1;  // second ACCESS cycle
    s1_stb = 1'b0; s1_cyc = 1'b0;
    @(posedge clk); #1;
    checks++; if (f_ce_n !== 1'b1 || f_oe_n !== 1'b1 || s1_ack !== 1'b0) begin
      errors++; $display("FAIL abort_release ce_n=%b oe_n=%b s1_ack=%b want 1 1 0",
                         f_ce_n, f_oe_n, s1_ack);
    end
    checks++; if (f_addr !== 22'h55) begin
      errors++; $display("FAIL abort_addr_hold addr=%h want 55", f_addr);
    end
    @(posedge clk); #1;
    checks++; if (f_addr !== 22'h77 || f_ce_n !== 1'b0) begin
      errors++; $display("FAIL abort_s0_grant addr=%h ce_n=%b want 77 0", f_addr, f_ce_n);
    end
    repeat (5) @(posedge clk); #1;
    checks++; if (s0_ack !== 1'b1 || s0_dat !== 16'hA5D2) begin
      errors++; $display("FAIL abort_s0_ack ack=%b dat=%h want 1 A5D2", s0_ack, s0_dat);
    end
    s0_stb = 1'b0; s0_cyc = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (ack1_cnt !== a1) begin
      errors++; $display("FAIL abort_no_s1_ack count=%0d want %0d", ack1_cnt, a1);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    s0_adr = 22'h101; s1_adr = 22'h202;
    s0_stb = 1'b1; s0_cyc = 1'b1; s1_stb = 1'b1; s1_cyc = 1'b1;
    repeat (3) @(posedge clk); #1;  // grant then two ACCESS cycles
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (s0_ack !== 1'b0 || s1_ack !== 1'b0 || f_ce_n !== 1'b1 || f_oe_n !== 1'b1) begin
      errors++; $display("FAIL rstmid_ctrl acks=%b%b ce_n=%b oe_n=%b want 00 1 1",
                         s0_ack, s1_ack, f_ce_n, f_oe_n);
    end
    checks++; if (f_addr !== 22'h0) begin
      errors++; $display("FAIL rstmid_addr addr=%h want 0", f_addr);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (f_addr !== 22'h101 || f_ce_n !== 1'b0) begin
      errors++; $display("FAIL rstmid_tie addr=%h ce_n=%b want 101 0", f_addr, f_ce_n);
    end
    idle_inputs();
    repeat (8) @(posedge clk); #1;
  endtask

  task automatic test_wait0;
    do_reset();
    s0_adr = 22'h3FFFFF; s0_stb = 1'b1; s0_cyc = 1'b1;
    @(posedge clk); #1;
    checks++; if (z_ce_n !== 1'b0 || z_oe_n !== 1'b0 || z_s0_ack !== 1'b0) begin
      errors++; $display("FAIL w0_grant ce_n=%b oe_n=%b ack=%b want 0 0 0",
                         z_ce_n, z_oe_n, z_s0_ack);
    end
    @(posedge clk); #1;
    checks++; if (z_s0_ack !== 1'b1 || z_s0_dat !== 16'h0001 || z_ce_n !== 1'b1) begin
      errors++; $display("FAIL w0_ack ack=%b dat=%h ce_n=%b want 1 0001 1",
                         z_s0_ack, z_s0_dat, z_ce_n);
    end
    s0_stb = 1'b0; s0_cyc = 1'b0;
    @(posedge clk); #1;
    checks++; if (z_s0_ack !== 1'b0 || z_s0_dat !== 16'h0001) begin
      errors++; $display("FAIL w0_drop ack=%b dat=%h want 0 0001", z_s0_ack, z_s0_dat);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_simultaneous();
    test_fairness();
    test_abort();
    test_reset_mid();
    test_wait0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flash_arb_ctrl.md
Name: flash_arb_ctrl

Overview:
- Read-only flash access controller that shares the DE0 parallel NOR flash pads between two Wishbone slave ports.
- Port 0 serves CPU ROM/BIOS fetches; port 1 serves the boot-time shadow copier.
- Grants one access at a time, round-robin between ports.
- Drives CE#/OE# for a parameterised number of wait cycles, registers the read data and returns a single-cycle ack.

Parameters:
- WAIT_CYCLES, 4: extra cycles OE#/CE# stay low before data capture. Pad-active time is WAIT_CYCLES+1 clocks. Legal range 0..15.
- CNT_W, 4: wait counter width. Must satisfy 2^CNT_W > WAIT_CYCLES.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  reset; synchronous, active-high
- s0_adr_i  in  22  port 0 word address
- s0_stb_i  in  1  port 0 strobe
- s0_cyc_i  in  1  port 0 cycle
- s0_dat_o  out  16  port 0 read data
- s0_ack_o  out  1  port 0 acknowledge
- s1_adr_i  in  22  port 1 word address
- s1_stb_i  in  1  port 1 strobe
- s1_cyc_i  in  1  port 1 cycle
- s1_dat_o  out  16  port 1 read data
- s1_ack_o  out  1  port 1 acknowledge
- flash_addr_  out  22  flash word address
- flash_data_  in  16  flash data bus
- flash_we_n_  out  1  write enable, tied 1
- flash_oe_n_  out  1  output enable, active-low
- flash_ce_n_  out  1  chip enable, active-low
- flash_rst_n_  out  1  flash reset, tied 1

Behaviour:
- Clock and reset: one clock, wb_clk_i. wb_rst_i is synchronous and active-high.
- Reset values:
  - state=IDLE, cnt=0, last_gnt=1 (so port 0 wins the first tie).
  - s0_ack_o=s1_ack_o=0.
  - flash_oe_n_=flash_ce_n_=1, flash_addr_=0, data register=0.
- Reset asserted mid-access forces these values at the next edge. No ack is issued.
- Request: reqN = sN_stb_i & sN_cyc_i. Writes are not supported; the we signal is not decoded.
- IDLE:
  - Only one requester: grant it.
  - Both requesting: grant the port that is not last_gnt, then set last_gnt to the granted port.
  - On grant, register flash_addr_ from the granted adr, drive oe_n/ce_n low, load cnt=WAIT_CYCLES, go to ACCESS.
- ACCESS:
  - Granted port's cyc_i low (abort): release oe_n/ce_n, go to IDLE, no ack.
  - Else if cnt==0: capture flash_data_ into the data register, assert the granted port's ack, release oe_n/ce_n, go to ACK.
  - Else: cnt decrements.
- ACK: drop ack and go to IDLE. This state is a mandatory one-cycle gap so the master's still-high stb is not re-sampled as a new request.
- Timing: a request sampled at edge N gives pads active from N to N+1+WAIT_CYCLES and ack high for exactly one cycle after edge N+1+WAIT_CYCLES. The earliest next grant is edge N+3+WAIT_CYCLES.
- Read data: s0_dat_o and s1_dat_o both drive the data register. Data is valid only while the matching ack is high, and the register holds its value otherwise.
- Addressing: flash_addr_ holds its value after release, so there is no glitch on the address pads.
- Exclusivity: at most one ack is high in any cycle. A non-granted requester waits with no ack.
- Address changes on the granted port during ACCESS are ignored; the address is latched at grant.

Decomposition:
- flash_pkg holds:
  - state enum {IDLE, ACCESS, ACK}
  - port index constants P0/P1
  - default WAIT_CYCLES
- One sub-module, flash_rr_arb: 2-way round-robin arbiter. Inputs are req[1:0], last_gnt and an enable; outputs are a one-hot gnt[1:0] and gnt_idx. It is purely combinational; last_gnt stays in the parent.

Test Plan:
- Single read: s0 reads address 22'h000123 with flash model returning 16'hBEEF, WAIT_CYCLES=4 → ce_n/oe_n low for 5 cycles, s0_ack_o high for 1 cycle at the 6th edge after the request, s0_dat_o=16'hBEEF.
- Simultaneous requests from reset: s0 reads 22'h10, s1 reads 22'h20 → s0 is served first; s1 is granted at the first IDLE after the ACK gap. flash_addr_ sequence 22'h10 then 22'h20. Acks never overlap.
- Fairness: both ports hold continuous back-to-back requests for 8 accesses → grants alternate 0,1,0,1…, and each port gets 4 acks.
- Abort: s1 drops cyc at cycle 2 of ACCESS → no s1_ack_o, ce_n/oe_n high the next edge, and a pending s0 is granted from IDLE.
- Reset mid-access: assert wb_rst_i during ACCESS → the next edge shows both acks 0, ce_n/oe_n=1 and flash_addr_=0. After release, s0 wins a tie.
- WAIT_CYCLES=0 build: read of 22'h3FFFFF returning 16'h0001 → pads active for 1 cycle, ack 2 cycles after the request, data 16'h0001.
